// File: rtl/reg_array_slot_ctrl_if.sv
// Slot-FIFO controller bus: beat input, group size, flush, OPU pop and status.
// master drives beats/pops (upstream + OPU side), slave is the controller.
interface reg_array_slot_ctrl_if #(
   parameter int PTR_W = 3,
   parameter int CNT_W = 4
);
   logic             RDATA_VLD;
   logic [CNT_W-1:0] num_rdata_i;
   logic             FLUSH;
   logic             OPU_RDY;
   logic             grp_done;
   logic [CNT_W-1:0] beat_idx;
   logic [PTR_W-1:0] wr_slot;
   logic [PTR_W-1:0] rd_slot;
   logic [PTR_W:0]   level;
   logic             reg_array_full;
   logic             reg_array_empty;
   logic             reg_array_afull;
   logic             rdata_stall;
   logic             err_ovf;
   logic             err_udf;

   modport master (
      output RDATA_VLD, num_rdata_i, FLUSH, OPU_RDY,
      input  grp_done, beat_idx, wr_slot, rd_slot, level,
             reg_array_full, reg_array_empty, reg_array_afull, rdata_stall,
             err_ovf, err_udf
   );

   modport slave (
      input  RDATA_VLD, num_rdata_i, FLUSH, OPU_RDY,
      output grp_done, beat_idx, wr_slot, rd_slot, level,
             reg_array_full, reg_array_empty, reg_array_afull, rdata_stall,
             err_ovf, err_udf
   );
endinterface

// File: rtl/reg_array_slot_ctrl.sv
// reg_array slot-FIFO controller: groups RDATA_VLD beats into slots of a
// per-group programmable size and pops one slot per OPU_RDY.
// Optional sticky error flags are built when REG_ARRAY_SLOT_ERR_EN is defined;
// otherwise err_ovf/err_udf are tied low.
module reg_array_slot_ctrl #(
   parameter int PTR_W    = 3,
   parameter int CNT_W    = 4,
   parameter int AFULL_TH = 6
) (
   input logic                  SYS_CLK,
   input logic                  SYS_NRST,
   reg_array_slot_ctrl_if.slave rif
);
   localparam logic [PTR_W:0]   DEPTH     = {1'b1, {PTR_W{1'b0}}};
   localparam logic [PTR_W:0]   AFULL_LVL = (PTR_W+1)'(AFULL_TH);
   localparam logic [PTR_W:0]   PTR_ONE   = (PTR_W+1)'(1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   typedef enum logic {ST_IDLE, ST_FILL} state_t;

   state_t           state;
   logic [PTR_W:0]   wptr;
   logic [PTR_W:0]   rptr;
   logic [CNT_W-1:0] beat_cnt;
   logic [CNT_W-1:0] r_num;
   logic [CNT_W-1:0] num_eff;
   logic [PTR_W:0]   level;
   logic             full;
   logic             empty;
   logic             acc;
   logic             pop;
   logic             last_beat;

   // Occupancy flags straight from the registered pointers
   always_comb begin
      level   = wptr - rptr;
      full    = (level == DEPTH);
      empty   = (level == '0);
      num_eff = (rif.num_rdata_i == '0) ? CNT_ONE : rif.num_rdata_i;
      acc     = rif.RDATA_VLD & ~full & ~rif.FLUSH;
      pop     = rif.OPU_RDY & ~empty & ~rif.FLUSH;
      // A size-1 group completes on its first beat straight from IDLE
      if (state == ST_IDLE)
         last_beat = acc & (num_eff == CNT_ONE);
      else
         last_beat = acc & (beat_cnt == r_num - CNT_ONE);
   end

   // Group FSM, beat counter and slot pointers; FLUSH outranks push/pop
   always_ff @(posedge SYS_CLK or negedge SYS_NRST) begin
      if (!SYS_NRST) begin
         state    <= ST_IDLE;
         wptr     <= '0;
         rptr     <= '0;
         beat_cnt <= '0;
         r_num    <= CNT_ONE;
      end else if (rif.FLUSH) begin
         state    <= ST_IDLE;
         wptr     <= '0;
         rptr     <= '0;
         beat_cnt <= '0;
      end else begin
         if (acc) begin
            if (last_beat) begin
               wptr     <= wptr + PTR_ONE;
               beat_cnt <= '0;
               state    <= ST_IDLE;
               if (state == ST_IDLE)
                  r_num <= num_eff;
            end else if (state == ST_IDLE) begin
               r_num    <= num_eff;
               beat_cnt <= CNT_ONE;
               state    <= ST_FILL;
            end else begin
               beat_cnt <= beat_cnt + CNT_ONE;
            end
         end
         if (pop)
            rptr <= rptr + PTR_ONE;
      end
   end

`ifdef REG_ARRAY_SLOT_ERR_EN
   logic err_ovf_q;
   logic err_udf_q;

   // Sticky overflow/underflow flags, cleared only by FLUSH or reset
   always_ff @(posedge SYS_CLK or negedge SYS_NRST) begin
      if (!SYS_NRST) begin
         err_ovf_q <= 1'b0;
         err_udf_q <= 1'b0;
      end else if (rif.FLUSH) begin
         err_ovf_q <= 1'b0;
         err_udf_q <= 1'b0;
      end else begin
         if (rif.RDATA_VLD & full)
            err_ovf_q <= 1'b1;
         if (rif.OPU_RDY & empty)
            err_udf_q <= 1'b1;
      end
   end

   assign rif.err_ovf = err_ovf_q;
   assign rif.err_udf = err_udf_q;
`else
   assign rif.err_ovf = 1'b0;
   assign rif.err_udf = 1'b0;
`endif

   assign rif.grp_done        = last_beat;
   assign rif.beat_idx        = beat_cnt;
   assign rif.wr_slot         = wptr[PTR_W-1:0];
   assign rif.rd_slot         = rptr[PTR_W-1:0];
   assign rif.level           = level;
   assign rif.reg_array_full  = full;
   assign rif.reg_array_empty = empty;
   assign rif.reg_array_afull = (level >= AFULL_LVL);
   assign rif.rdata_stall     = full;
endmodule

// File: tb/tb_reg_array_slot_ctrl.sv
// Directed bench for reg_array_slot_ctrl (PTR_W=3, CNT_W=4, AFULL_TH=6).
module tb_reg_array_slot_ctrl;
`ifdef REG_ARRAY_SLOT_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   typedef struct {
      logic       vld;
      logic [3:0] num;
      logic       flush;
      logic       rdy;
      logic       gd;
      logic [3:0] bidx;
      logic [2:0] ws;
      logic [2:0] rs;
      logic [3:0] lvl;
   } vec_t;

   logic SYS_CLK  = 1'b0;
   logic SYS_NRST = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;

   reg_array_slot_ctrl_if #(.PTR_W(3), .CNT_W(4)) bus ();

   reg_array_slot_ctrl #(.PTR_W(3), .CNT_W(4), .AFULL_TH(6)) dut (
      .SYS_CLK  (SYS_CLK),
      .SYS_NRST (SYS_NRST),
      .rif      (bus.slave)
   );

   always #5 SYS_CLK = ~SYS_CLK;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_state(input string tag, input int gd, input int bidx,
                            input int ws, input int rs, input int lvl);
      chk({tag, " grp_done"}, 32'(bus.grp_done), 32'(gd));
      chk({tag, " beat_idx"}, 32'(bus.beat_idx), 32'(bidx));
      chk({tag, " wr_slot"},  32'(bus.wr_slot),  32'(ws));
      chk({tag, " rd_slot"},  32'(bus.rd_slot),  32'(rs));
      chk({tag, " level"},    32'(bus.level),    32'(lvl));
      chk({tag, " full"},     32'(bus.reg_array_full),  32'(lvl == 8));
      chk({tag, " stall"},    32'(bus.rdata_stall),     32'(lvl == 8));
      chk({tag, " empty"},    32'(bus.reg_array_empty), 32'(lvl == 0));
      chk({tag, " afull"},    32'(bus.reg_array_afull), 32'(lvl >= 6));
   endtask

   task automatic drive(input logic vld, input logic [3:0] num, input logic flush, input logic rdy);
      @(negedge SYS_CLK);
      bus.RDATA_VLD   = vld;
      bus.num_rdata_i = num;
      bus.FLUSH       = flush;
      bus.OPU_RDY     = rdy;
      #1;
   endtask

   function automatic vec_t mk(input logic vld, input logic [3:0] num, input logic flush,
                               input logic rdy, input logic gd, input logic [3:0] bidx,
                               input logic [2:0] ws, input logic [2:0] rs, input logic [3:0] lvl);
      vec_t v;
      v.vld = vld; v.num = num; v.flush = flush; v.rdy = rdy;
      v.gd = gd; v.bidx = bidx; v.ws = ws; v.rs = rs; v.lvl = lvl;
      return v;
   endfunction

   initial begin
      vec_t tbl[$];
      int   exp_w;
      int   exp_r;
      int   pops;
      int   lvl_now;
      bit   gd_now;

      bus.RDATA_VLD   = 1'b0;
      bus.num_rdata_i = '0;
      bus.FLUSH       = 1'b0;
      bus.OPU_RDY     = 1'b0;

      // Row checks describe state left by the previous edge plus the
      // combinational grp_done for the row's own inputs.
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      for (int k = 1; k <= 9; k++)
         tbl.push_back(mk(1, 9, 0, 0, (k == 9), 4'(k - 1), 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1));
      tbl.push_back(mk(1, 0, 0, 0, 1, 0, 1, 0, 1));
      tbl.push_back(mk(1, 1, 0, 0, 1, 0, 2, 0, 2));
      tbl.push_back(mk(1, 2, 0, 0, 0, 0, 3, 0, 3));
      tbl.push_back(mk(1, 5, 0, 0, 1, 1, 3, 0, 3));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 4, 0, 4));
      tbl.push_back(mk(1, 2, 0, 0, 0, 0, 4, 0, 4));
      tbl.push_back(mk(1, 0, 0, 1, 1, 1, 4, 0, 4));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 5, 1, 4));
      tbl.push_back(mk(1, 3, 0, 0, 0, 0, 5, 1, 4));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 5, 1, 4));
      tbl.push_back(mk(1, 0, 0, 1, 0, 1, 5, 1, 4));
      tbl.push_back(mk(1, 0, 0, 0, 1, 2, 5, 2, 3));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 6, 2, 4));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 6, 2, 4));
      for (int k = 0; k < 5; k++)
         tbl.push_back(mk(1, 9, 0, 0, 0, 4'(k), 6, 3, 3));
      tbl.push_back(mk(1, 0, 1, 1, 0, 5, 6, 3, 3));
      tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

      // Asynchronous reset state
      #3;
      chk_state("reset", 0, 0, 0, 0, 0);
      chk("reset err_ovf", 32'(bus.err_ovf), 0);
      chk("reset err_udf", 32'(bus.err_udf), 0);
      @(negedge SYS_CLK);
      @(negedge SYS_CLK);
      SYS_NRST = 1'b1;

      foreach (tbl[i]) begin
         drive(tbl[i].vld, tbl[i].num, tbl[i].flush, tbl[i].rdy);
         chk_state($sformatf("row%0d", i), tbl[i].gd, tbl[i].bidx, tbl[i].ws, tbl[i].rs, tbl[i].lvl);
      end

      // Eight back-to-back 3-beat groups fill the array
      for (int g = 0; g < 8; g++)
         for (int b = 0; b < 3; b++) begin
            drive(1, 3, 0, 0);
            chk_state($sformatf("fill g%0d b%0d", g, b), (b == 2), b, g, 0, g);
         end
      drive(1, 3, 0, 0);
      chk_state("beat25", 0, 0, 0, 0, 8);
      drive(1, 3, 0, 1);
      chk_state("full pop", 0, 0, 0, 0, 8);
      chk("ovf sticky", 32'(bus.err_ovf), 32'(ERR_EN));
      drive(0, 0, 0, 0);
      chk_state("after full pop", 0, 0, 0, 1, 7);
      chk("ovf held", 32'(bus.err_ovf), 32'(ERR_EN));
      drive(0, 0, 1, 0);
      drive(0, 0, 0, 0);
      chk_state("flush clear", 0, 0, 0, 0, 0);
      chk("flush err_ovf", 32'(bus.err_ovf), 0);

      // 20 groups streamed through with OPU always ready; pointers wrap
      exp_w = 0;
      exp_r = 0;
      pops  = 0;
      for (int c = 0; c < 63; c++) begin
         drive((c < 60), 3, 0, 1);
         lvl_now = exp_w - exp_r;
         gd_now  = (c < 60) && (c % 3 == 2);
         chk_state($sformatf("stream c%0d", c), gd_now, (c < 60) ? c % 3 : 0,
                   exp_w % 8, exp_r % 8, lvl_now);
         if (lvl_now > 0) begin
            exp_r++;
            pops++;
         end
         if (gd_now)
            exp_w++;
      end
      chk("stream pops", 32'(pops), 20);
      chk("stream wptr", 32'(exp_w), 20);
      chk("underflow flag", 32'(bus.err_udf), 32'(ERR_EN));

      // Async reset in the middle of a group with three slots held
      for (int k = 0; k < 3; k++)
         drive(1, 1, 0, 0);
      for (int k = 0; k < 5; k++)
         drive(1, 9, 0, 0);
      drive(0, 0, 0, 0);
      chk_state("pre reset", 0, 5, 7, 4, 3);
      #2;
      SYS_NRST = 1'b0;
      #1;
      chk_state("async reset", 0, 0, 0, 0, 0);
      chk("async reset err_udf", 32'(bus.err_udf), 0);
      chk("async reset err_ovf", 32'(bus.err_ovf), 0);
      @(negedge SYS_CLK);
      SYS_NRST = 1'b1;
      drive(0, 0, 0, 0);
      chk_state("post reset", 0, 0, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
